pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Owns the program counter of the pipelined MIPS core and sequences it every cycle. It selects the next PC among sequential, branch, jump and jump-register targets, and computes the branch target internally as ID-stage PC+4 plus the sign-extended offset shifted left by 2. It generates the IF/ID flush on every redirect and runs the halt-drain state machine that the debug unit observes. It sits between the instruction memory address port, the ID-stage decode/compare logic, the hazard unit and the debug unit.

## Interface
- N_BITS_DW, 32, PC / data width
- N_BITS_W, 16, branch immediate width
- N_BITS_JMP, 26, J-type index width
- RESET_PC, 0, PC value after reset
- N_DRAIN, 4, cycles to wait after HALT before asserting halted
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  debug run/step enable; 0 freezes all state
- i_stall  in  1  load-use stall from hazard unit
- i_halt  in  1  HALT decoded in ID
- i_branch  in  1  BEQ/BNE in ID
- i_branch_taken  in  1  ID comparator result
- i_imm  in  N_BITS_W  branch offset, in words
- i_jump  in  1  J/JAL in ID
- i_jump_index  in  N_BITS_JMP  J-type index
- i_jump_reg  in  1  JR/JALR in ID
- i_reg_target  in  N_BITS_DW  forwarded rs value
- o_pc  out  N_BITS_DW  fetch address
- o_pc_plus4  out  N_BITS_DW  o_pc+4, for the IF/ID register
- o_flush_if  out  1  zero the IF/ID register this edge
- o_redirect  out  1  non-sequential PC taken this cycle
- o_halted  out  1  pipeline drained after HALT
- o_taken_count  out  16  redirect counter (see Configuration)

## Operation
- Internal r_pc_id holds PC+4 of the instruction currently in ID. It loads o_pc_plus4 on every advancing edge: enable=1, stall=0, state RUN, no redirect. On a redirect edge it loads RESET_PC's slot value 0, matching the bubble.
- Branch target: r_pc_id + ({{16{i_imm[15]}},i_imm} << 2), mod 2^32.
- Jump target: {r_pc_id[31:28], i_jump_index, 2'b00}.
- Next-PC priority, valid only in RUN with enable=1:
  - stall: hold o_pc, no flush, no redirect
  - halt: hold o_pc, go to DRAIN
  - jump_reg: i_reg_target
  - jump: jump target
  - branch && branch_taken: branch target
  - otherwise: o_pc+4
- Not-taken branch is sequential, with no flush.
- o_redirect = o_flush_if = enable && RUN && !stall && !halt && (jump_reg || jump || (branch && taken)). Both are combinational. No delay slot: the fetched instruction is killed.
- States:
  - IDLE: after reset. Goes to RUN on the first enable=1.
  - RUN: normal sequencing as above.
  - DRAIN: PC frozen, o_flush_if=1 each enabled cycle. An internal counter counts N_DRAIN enabled cycles, then the FSM goes to HALTED.
  - HALTED: o_halted=1. Only reset exits.
- enable=0 in any state: no register changes, o_flush_if=0, o_redirect=0.

## Timing
- Reset (asynchronous, mid-operation included): o_pc=RESET_PC, r_pc_id=0, state IDLE, drain counter 0, o_halted=0, o_taken_count=0, o_flush_if=0, o_redirect=0.
- The redirect decision is combinational in cycle N. o_pc shows the target after edge N.
- i_halt together with i_jump: halt wins and there is no redirect.
- i_stall together with a redirect request: the stall wins and the redirect is re-evaluated on the next cycle, because ID still holds the instruction.
- PC wraps mod 2^32. Negative offsets below 0 wrap.
- DRAIN with enable toggling: only enabled cycles count.

## Configuration
- PC_SEQ_STATS_EN defined: o_taken_count increments by 1 on every edge where o_redirect=1. It is 16-bit and wraps 0xFFFF→0.
- PC_SEQ_STATS_EN undefined: o_taken_count is tied to 0 and no counter is synthesized.

## Test plan
- Reset low, then high with enable=1, sequential run: o_pc goes 0,4,8,12 on successive edges; o_flush_if stays 0.
- At o_pc=0x10 (r_pc_id=0x10), branch=1, taken=1, imm=0xFFFC → o_flush_if=1 that cycle; next o_pc=0x0.
- jump=1, index=0x000040, with r_pc_id=0x1000_0008 → next o_pc=0x1000_0100. Simultaneous jump_reg=1, reg_target=0x200 → next o_pc=0x200.
- stall=1 with jump=1 for 2 cycles → o_pc held, no flush. Stall then released → redirect on the following edge.
- halt=1 at o_pc=0x20 → o_pc stays 0x20, o_flush_if=1 for 4 enabled cycles, then o_halted=1. Reset asserted afterwards → o_pc=0, o_halted=0.
- With PC_SEQ_STATS_EN defined: 3 taken redirects plus 1 not-taken branch → o_taken_count=3. Without the macro → o_taken_count=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencing, redirect/flush generation and halt-drain FSM.
// Define PC_SEQ_STATS_EN to build the 16-bit taken-redirect counter.
module pc_sequencer #(
    parameter int N_BITS_DW  = 32,
    parameter int N_BITS_W   = 16,
    parameter int N_BITS_JMP = 26,
    parameter logic [N_BITS_DW-1:0] RESET_PC = '0,
    parameter int N_DRAIN    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_stall,
    input  logic                  i_halt,
    input  logic                  i_branch,
    input  logic                  i_branch_taken,
    input  logic [N_BITS_W-1:0]   i_imm,
    input  logic                  i_jump,
    input  logic [N_BITS_JMP-1:0] i_jump_index,
    input  logic                  i_jump_reg,
    input  logic [N_BITS_DW-1:0]  i_reg_target,
    output logic [N_BITS_DW-1:0]  o_pc,
    output logic [N_BITS_DW-1:0]  o_pc_plus4,
    output logic                  o_flush_if,
    output logic                  o_redirect,
    output logic                  o_halted,
    output logic [15:0]           o_taken_count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;
    localparam int CW = $clog2(N_DRAIN) + 1;

    state_t               state, state_nx;
    logic [CW-1:0]        drain_cnt;
    logic [N_BITS_DW-1:0] r_pc_id, pc_nx, br_target, jmp_target;
    logic                 run, advance, taken_br;

    assign o_pc_plus4 = o_pc + N_BITS_DW'(4);
    assign br_target  = r_pc_id + ({{(N_BITS_DW-N_BITS_W){i_imm[N_BITS_W-1]}}, i_imm} << 2);
    assign jmp_target = {r_pc_id[N_BITS_DW-1 -: N_BITS_DW-N_BITS_JMP-2], i_jump_index, 2'b00};

    always_comb begin
        run        = i_enable && state == RUN;
        advance    = run && !i_stall;
        taken_br   = i_branch && i_branch_taken;
        o_redirect = advance && !i_halt && (i_jump_reg || i_jump || taken_br);
        o_flush_if = o_redirect || (i_enable && state == DRAIN);
        o_halted   = state == HALTED;
        pc_nx      = i_jump_reg ? i_reg_target : i_jump ? jmp_target : taken_br ? br_target : o_pc_plus4;
        state_nx   = state;
        if (i_enable)
            case (state)
                IDLE:    state_nx = RUN;
                RUN:     state_nx = (!i_stall && i_halt) ? DRAIN : RUN;
                DRAIN:   state_nx = (drain_cnt == CW'(N_DRAIN - 1)) ? HALTED : DRAIN;
                default: state_nx = state;
            endcase
    end

    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) state <= IDLE;
        else          state <= state_nx;

    // r_pc_id is cleared on a redirect so it matches the bubble left in IF/ID
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_pc      <= RESET_PC;
            r_pc_id   <= '0;
            drain_cnt <= '0;
        end else begin
            if (advance && !i_halt) o_pc <= pc_nx;
            if (advance) r_pc_id <= o_redirect ? '0 : o_pc_plus4;
            if (i_enable && state == DRAIN) drain_cnt <= drain_cnt + CW'(1);
        end
    end

`ifdef PC_SEQ_STATS_EN
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset)        o_taken_count <= '0;
        else if (o_redirect) o_taken_count <= o_taken_count + 16'd1;
`else
    assign o_taken_count = '0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer.
module tb_pc_sequencer;
    logic        clk = 0, rst_n = 0, en = 0, stall = 0, halt = 0, br = 0, tk = 0, jmp = 0, jr = 0;
    logic [15:0] imm = '0;
    logic [25:0] idx = '0;
    logic [31:0] tgt = '0;
    logic [31:0] pc, pc4;
    logic        flush, redir, halted;
    logic [15:0] cnt;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fl, rd, hl;
        logic [15:0] cnt;
    } exp_t;
    exp_t        q[$];
    int          n_chk = 0, n_fail = 0;
    logic [15:0] exp_cnt = '0;

    pc_sequencer dut (
        .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_stall(stall), .i_halt(halt),
        .i_branch(br), .i_branch_taken(tk), .i_imm(imm), .i_jump(jmp), .i_jump_index(idx),
        .i_jump_reg(jr), .i_reg_target(tgt), .o_pc(pc), .o_pc_plus4(pc4), .o_flush_if(flush),
        .o_redirect(redir), .o_halted(halted), .o_taken_count(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", n, f, act, req);
        end
    endtask

    always @(negedge clk)
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "pc", pc, e.pc);
            chk(e.name, "pc_plus4", pc4, e.pc + 32'd4);
            chk(e.name, "flush", {31'd0, flush}, {31'd0, e.fl});
            chk(e.name, "redirect", {31'd0, redir}, {31'd0, e.rd});
            chk(e.name, "halted", {31'd0, halted}, {31'd0, e.hl});
            chk(e.name, "taken_count", {16'd0, cnt}, {16'd0, e.cnt});
        end

    task automatic push(input string n, input logic [31:0] p, input logic fl, rd, hl);
        q.push_back('{n, p, fl, rd, hl, exp_cnt});
`ifdef PC_SEQ_STATS_EN
        if (rd) exp_cnt++;
`endif
    endtask

    task automatic cyc(input string n, input logic e, s, h, b, t, input logic [15:0] im,
                       input logic j, input logic [25:0] ix, input logic r, input logic [31:0] tg,
                       input logic [31:0] p, input logic fl, rd, hl);
        @(posedge clk);
        #1;
        en = e; stall = s; halt = h; br = b; tk = t; imm = im; jmp = j; idx = ix; jr = r; tgt = tg;
        push(n, p, fl, rd, hl);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected end of sequence");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        push("reset", 32'h0, 0, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1;
        //   name         en st ht br tk imm       j  idx        jr tgt            pc            fl rd hl
        cyc("idle",       1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h0,        0, 0, 0);
        cyc("seq0",       1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h0,        0, 0, 0);
        cyc("seq4",       1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h4,        0, 0, 0);
        cyc("seq8",       1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h8,        0, 0, 0);
        cyc("seq12",      1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'hC,        0, 0, 0);
        cyc("br_back",    1, 0, 0, 1, 1, 16'hFFFC, 0, 26'h0,     0, 32'h0,         32'h10,       1, 1, 0);
        cyc("br_wrap",    1, 0, 0, 1, 1, 16'hFFFF, 0, 26'h0,     0, 32'h0,         32'h0,        1, 1, 0);
        cyc("jr",         1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     1, 32'h1000_0004, 32'hFFFF_FFFC, 1, 1, 0);
        cyc("seq_hi",     1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h1000_0004, 0, 0, 0);
        cyc("jump",       1, 0, 0, 0, 0, 16'h0,    1, 26'h40,    0, 32'h0,         32'h1000_0008, 1, 1, 0);
        cyc("jr_over_j",  1, 0, 0, 0, 0, 16'h0,    1, 26'h40,    1, 32'h200,       32'h1000_0100, 1, 1, 0);
        cyc("br_nt",      1, 0, 0, 1, 0, 16'h0010, 0, 26'h0,     0, 32'h0,         32'h200,      0, 0, 0);
        cyc("stall1",     1, 1, 0, 0, 0, 16'h0,    1, 26'h10,    0, 32'h0,         32'h204,      0, 0, 0);
        cyc("stall2",     1, 1, 0, 0, 0, 16'h0,    1, 26'h10,    0, 32'h0,         32'h204,      0, 0, 0);
        cyc("unstall",    1, 0, 0, 0, 0, 16'h0,    1, 26'h10,    0, 32'h0,         32'h204,      1, 1, 0);
        cyc("en_off",     0, 0, 0, 0, 0, 16'h0,    1, 26'h10,    0, 32'h0,         32'h40,       0, 0, 0);
        cyc("jr20",       1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     1, 32'h20,        32'h40,       1, 1, 0);
        cyc("halt_j",     1, 0, 1, 0, 0, 16'h0,    1, 26'h10,    0, 32'h0,         32'h20,       0, 0, 0);
        cyc("drain1",     1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h20,       1, 0, 0);
        cyc("drain_off",  0, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h20,       0, 0, 0);
        cyc("drain2",     1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h20,       1, 0, 0);
        cyc("drain3",     1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h20,       1, 0, 0);
        cyc("drain4",     1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h20,       1, 0, 0);
        cyc("halted",     1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h20,       0, 0, 1);
        cyc("halted_j",   1, 0, 0, 0, 0, 16'h0,    1, 26'h8,     1, 32'h80,        32'h20,       0, 0, 1);
        @(posedge clk);
        #1;
        rst_n = 0;
        en = 0; jmp = 0; jr = 0;
        exp_cnt = '0;
        push("mid_reset", 32'h0, 0, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1;
        cyc("post_idle",  1, 0, 0, 0, 0, 16'h0,    1, 26'h8,     0, 32'h0,         32'h0,        0, 0, 0);
        cyc("post_run",   1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h0,        0, 0, 0);
        cyc("post_seq",   1, 0, 0, 0, 0, 16'h0,    0, 26'h0,     0, 32'h0,         32'h4,        0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue: %0d pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
